// File: rtl/vdp_bridge_pkg.sv
// vdp_bridge_pkg: shared types and constants for the CPU-to-VDP command bridge.
package vdp_bridge_pkg;
  typedef enum logic [1:0] {IDLE, STROBE, GAP} state_t;
  localparam logic [1:0] ADDR_REG_SELECT = 2'd0;
  localparam logic [1:0] ADDR_REG_DATA   = 2'd1;
  localparam logic [1:0] ADDR_VRAM_DATA  = 2'd2;
  localparam logic [1:0] ADDR_STATUS     = 2'd3;
  localparam int ST_FULL     = 7;
  localparam int ST_EMPTY    = 6;
  localparam int ST_OVERFLOW = 5;
  localparam int ST_BUSY     = 4;
  typedef struct packed {
    logic [1:0] mode;
    logic [7:0] data;
  } cmd_t;
  function automatic int max3(input int a, input int b, input int c);
    return (a > b) ? ((a > c) ? a : c) : ((b > c) ? b : c);
  endfunction
endpackage

// File: rtl/vdp_cmd_fifo.sv
// vdp_cmd_fifo: first-word-fall-through synchronous FIFO with full/empty/count flags.
module vdp_cmd_fifo #(
  parameter int DEPTH = 8,
  parameter int WIDTH = 10
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wdata,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rdata,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  logic do_push, do_pop;
  assign do_pop  = pop & ~empty;
  // a pop in the same cycle frees the slot a full-FIFO push needs
  assign do_push = push & (~full | do_pop);
  assign full    = count == (AW+1)'(DEPTH);
  assign empty   = count == '0;
  assign rdata   = mem[rp];
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (do_push) wp <= wp + AW'(1);
      if (do_pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
  always_ff @(posedge clk)
    if (do_push) mem[wp] <= wdata;
endmodule

// File: rtl/vdp_cpu_bridge.sv
// vdp_cpu_bridge: synchronises async CPU writes, queues them and replays them as paced VDP write strobes.
module vdp_cpu_bridge
  import vdp_bridge_pkg::*;
#(
  parameter int FIFO_DEPTH      = 8,
  parameter int STROBE_CYCLES   = 2,
  parameter int VRAM_GAP_CYCLES = 32,
  parameter int REG_GAP_CYCLES  = 1
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       cpu_cs_n,
  input  logic       cpu_we_n,
  input  logic [1:0] cpu_addr,
  input  logic [7:0] cpu_data_in,
  output logic [7:0] cpu_data_out,
  output logic [1:0] vdp_mode,
  output logic       vdp_write,
  output logic       vdp_read,
  output logic [7:0] vdp_data,
  input  logic [7:0] vdp_data_rd
);
  localparam int CW = $clog2(max3(STROBE_CYCLES, VRAM_GAP_CYCLES, REG_GAP_CYCLES) + 1);
  logic [1:0] cs_s, we_s;
  logic wr_act, rd_act, wr_d, trail, push, pop, full, empty, overflow;
  logic [1:0] addr_r, mode_r;
  logic [7:0] data_r, status;
  logic [$clog2(FIFO_DEPTH):0] f_count;
  logic [CW-1:0] cnt, cnt_nx, gap_last;
  state_t state, state_nx;
  cmd_t wcmd, head;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cs_s <= 2'b11;
      we_s <= 2'b11;
    end else begin
      cs_s <= {cs_s[0], cpu_cs_n};
      we_s <= {we_s[0], cpu_we_n};
    end
  end
  assign wr_act = ~cs_s[1] & ~we_s[1];
  assign rd_act = ~cs_s[1] & we_s[1];
  assign trail  = wr_d & ~wr_act;
  assign push   = trail & (addr_r != ADDR_STATUS);
  assign pop    = (state == IDLE) & ~empty;
  assign wcmd   = '{mode: addr_r, data: data_r};
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_d   <= 1'b0;
      addr_r <= '0;
      data_r <= '0;
    end else begin
      wr_d <= wr_act;
      if (wr_act) begin
        addr_r <= cpu_addr;
        data_r <= cpu_data_in;
      end
    end
  end
  vdp_cmd_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH($bits(cmd_t))) u_fifo (
    .clk(clk), .reset_n(reset_n), .push(push), .wdata(wcmd), .pop(pop),
    .rdata(head), .full(full), .empty(empty), .count(f_count)
  );
  assign gap_last = (mode_r == ADDR_VRAM_DATA) ? CW'(VRAM_GAP_CYCLES - 1) : CW'(REG_GAP_CYCLES - 1);
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    unique case (state)
      IDLE: begin
        state_nx = empty ? IDLE : STROBE;
        cnt_nx   = '0;
      end
      STROBE: begin
        state_nx = (cnt == CW'(STROBE_CYCLES - 1)) ? GAP : STROBE;
        cnt_nx   = (cnt == CW'(STROBE_CYCLES - 1)) ? '0 : cnt + CW'(1);
      end
      GAP: begin
        state_nx = (cnt == gap_last) ? IDLE : GAP;
        cnt_nx   = (cnt == gap_last) ? '0 : cnt + CW'(1);
      end
      default: begin
        state_nx = IDLE;
        cnt_nx   = '0;
      end
    endcase
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      mode_r   <= '0;
      vdp_data <= '0;
      overflow <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (pop) begin
        mode_r   <= head.mode;
        vdp_data <= head.data;
      end
      if (trail && addr_r == ADDR_STATUS) overflow <= 1'b0;
      else if (push && full && !pop) overflow <= 1'b1;
    end
  end
  assign vdp_write    = state == STROBE;
  assign vdp_read     = rd_act & (cpu_addr != ADDR_STATUS) & (state == IDLE) & empty;
  assign vdp_mode     = vdp_read ? cpu_addr : mode_r;
  assign status       = {full, empty, overflow, state != IDLE, 4'(f_count)};
  assign cpu_data_out = !rd_act ? 8'h00 : (cpu_addr == ADDR_STATUS) ? status : vdp_data_rd;
endmodule

// File: tb/tb_vdp_cpu_bridge.sv
// tb_vdp_cpu_bridge: vector-table reads plus scoreboarded write/strobe sequences for vdp_cpu_bridge.
module tb_vdp_cpu_bridge;
  import vdp_bridge_pkg::*;
  logic clk = 1'b0, reset_n = 1'b0, cpu_cs_n = 1'b1, cpu_we_n = 1'b1;
  logic [1:0] cpu_addr = '0;
  logic [7:0] cpu_data_in = '0, vdp_data_rd = '0;
  logic [7:0] cpu_data_out, vdp_data;
  logic [1:0] vdp_mode;
  logic vdp_write, vdp_read;
  int checks = 0, failures = 0, cyc = 0, hi_cnt = 0;
  logic [9:0] exp_q[$];
  int rise_cyc[$];
  typedef struct {
    logic [1:0] addr;
    logic [7:0] rd_in;
    logic [7:0] exp_out;
    logic       exp_rd;
    logic [1:0] exp_mode;
    string      name;
  } rvec_t;

  vdp_cpu_bridge dut (
    .clk(clk), .reset_n(reset_n), .cpu_cs_n(cpu_cs_n), .cpu_we_n(cpu_we_n),
    .cpu_addr(cpu_addr), .cpu_data_in(cpu_data_in), .cpu_data_out(cpu_data_out),
    .vdp_mode(vdp_mode), .vdp_write(vdp_write), .vdp_read(vdp_read),
    .vdp_data(vdp_data), .vdp_data_rd(vdp_data_rd)
  );

  initial forever #5 clk = ~clk;
  initial forever begin
    @(posedge clk);
    cyc++;
  end

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  // strobe monitor: each rising vdp_write consumes one expected command
  initial forever begin
    @(negedge clk);
    if (!reset_n) hi_cnt = 0;
    else if (vdp_write) begin
      if (hi_cnt == 0) begin
        rise_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL strobe_unexpected: got cmd 0x%0h expected none", {vdp_mode, vdp_data});
        end else chk("strobe_cmd", int'({vdp_mode, vdp_data}), int'(exp_q.pop_front()));
      end
      hi_cnt++;
    end else if (hi_cnt != 0) begin
      chk("strobe_width", hi_cnt, 2);
      hi_cnt = 0;
    end
  end

  task automatic cpu_write(input logic [1:0] a, input logic [7:0] dat, input int hold,
                           input bit expct, output int rel);
    cpu_cs_n = 1'b0;
    cpu_we_n = 1'b0;
    cpu_addr = a;
    cpu_data_in = dat;
    if (expct) exp_q.push_back({a, dat});
    repeat (hold) @(negedge clk);
    cpu_cs_n = 1'b1;
    cpu_we_n = 1'b1;
    rel = cyc;
    repeat (2) @(negedge clk);
  endtask

  task automatic cpu_read(input logic [1:0] a, input logic [7:0] rdin, output logic [7:0] dout,
                          output logic rd, output logic [1:0] m);
    cpu_cs_n = 1'b0;
    cpu_we_n = 1'b1;
    cpu_addr = a;
    vdp_data_rd = rdin;
    repeat (3) @(negedge clk);
    dout = cpu_data_out;
    rd = vdp_read;
    m = vdp_mode;
    cpu_cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  task automatic wait_rises(input int n, input int lim);
    for (int i = 0; i < lim && rise_cyc.size() < n; i++) @(negedge clk);
    chk("strobe_arrived", int'(rise_cyc.size() >= n), 1);
  endtask

  task automatic drain(input int lim);
    for (int i = 0; i < lim && exp_q.size() != 0; i++) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rvec_t tbl[4];
    int n0, r1, rel;
    logic [7:0] d;
    logic rd;
    logic [1:0] m;
    tbl[0] = '{ADDR_STATUS,     8'h00, 8'h40, 1'b0, 2'd0, "rd_status_empty"};
    tbl[1] = '{ADDR_REG_SELECT, 8'h3C, 8'h3C, 1'b1, 2'd0, "rd_mode0"};
    tbl[2] = '{ADDR_REG_DATA,   8'hA5, 8'hA5, 1'b1, 2'd1, "rd_mode1"};
    tbl[3] = '{ADDR_VRAM_DATA,  8'hC3, 8'hC3, 1'b1, 2'd2, "rd_mode2"};
    repeat (3) @(negedge clk);
    chk("rst_write", vdp_write, 0);
    chk("rst_read", vdp_read, 0);
    chk("rst_mode", vdp_mode, 0);
    chk("rst_data", vdp_data, 0);
    chk("rst_cpu_out", cpu_data_out, 0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    for (int i = 0; i < 4; i++) begin
      cpu_read(tbl[i].addr, tbl[i].rd_in, d, rd, m);
      chk({tbl[i].name, "_data"}, d, tbl[i].exp_out);
      chk({tbl[i].name, "_vdp_read"}, rd, tbl[i].exp_rd);
      chk({tbl[i].name, "_mode"}, m, tbl[i].exp_mode);
    end

    n0 = rise_cyc.size();
    cpu_write(ADDR_REG_SELECT, 8'h05, 3, 1'b1, rel);
    wait_rises(n0 + 1, 20);
    if (rise_cyc.size() > n0) chk("write_latency_le4", int'(rise_cyc[n0] - rel <= 4), 1);
    drain(100);
    chk("single_strobe_count", rise_cyc.size() - n0, 1);

    n0 = rise_cyc.size();
    cpu_write(ADDR_VRAM_DATA, 8'hAA, 3, 1'b1, rel);
    cpu_write(ADDR_VRAM_DATA, 8'h55, 3, 1'b1, rel);
    wait_rises(n0 + 2, 100);
    if (rise_cyc.size() > n0 + 1) chk("vram_spacing", rise_cyc[n0 + 1] - rise_cyc[n0], 35);
    drain(200);

    n0 = rise_cyc.size();
    for (int i = 0; i < 10; i++) cpu_write(ADDR_VRAM_DATA, 8'h10 + 8'(i), 1, i < 9, rel);
    cpu_read(ADDR_STATUS, 8'h00, d, rd, m);
    chk("ovf_status", d, 8'hB8);
    chk("ovf_status_no_vdp_read", rd, 0);
    cpu_write(ADDR_STATUS, 8'h00, 1, 1'b0, rel);
    cpu_read(ADDR_STATUS, 8'h00, d, rd, m);
    chk("ovf_cleared", d[ST_OVERFLOW], 0);
    drain(2000);
    chk("ovf_strobe_count", rise_cyc.size() - n0, 9);

    n0 = rise_cyc.size();
    for (int i = 0; i < 9; i++) cpu_write(ADDR_VRAM_DATA, 8'h80 + 8'(i), 1, 1'b1, rel);
    wait_rises(n0 + 1, 10);
    r1 = (rise_cyc.size() > n0) ? rise_cyc[n0] : cyc;
    for (int i = 0; i < 100 && cyc < r1 + 31; i++) @(negedge clk);
    chk("pushpop_align", cyc, r1 + 31);
    cpu_write(ADDR_VRAM_DATA, 8'h99, 1, 1'b1, rel);
    cpu_read(ADDR_STATUS, 8'h00, d, rd, m);
    chk("pushpop_status", d, 8'h98);
    drain(2000);
    chk("pushpop_strobe_count", rise_cyc.size() - n0, 10);

    n0 = rise_cyc.size();
    cpu_write(ADDR_VRAM_DATA, 8'h61, 3, 1'b1, rel);
    cpu_write(ADDR_REG_DATA, 8'h62, 3, 1'b1, rel);
    cpu_write(ADDR_REG_DATA, 8'h63, 3, 1'b1, rel);
    wait_rises(n0 + 2, 100);
    chk("pre_reset_write", vdp_write, 1);
    #2 reset_n = 1'b0;
    #1;
    chk("reset_write_drop", vdp_write, 0);
    chk("reset_data", vdp_data, 0);
    chk("reset_mode", vdp_mode, 0);
    exp_q.delete();
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    repeat (50) @(negedge clk);
    chk("post_reset_no_strobe", rise_cyc.size() - n0, 2);
    cpu_read(ADDR_STATUS, 8'h00, d, rd, m);
    chk("post_reset_status", d, 8'h40);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end
endmodule
